mux16_scan_capture: RTL and testbench

MUX16_SCAN_CAPTURE -- requirements
Module: mux16_scan_capture

---
 rtl/mux16_scan_capture_pkg.sv | 17 +
 rtl/mux16_scan_capture_settle_timer.sv | 28 ++
 rtl/mux16_scan_capture.sv | 128 ++++++++++++
 tb/tb_mux16_scan_capture.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux16_scan_capture_pkg.sv
// Shared types and sizes for the 16:1 mux scan-capture block.
// Holds the FSM state encoding and the scan/select widths.
package mux16_scan_capture_pkg;

  localparam int SCAN_WIDTH = 16;
  localparam int SEL_WIDTH  = 4;

  localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(SCAN_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/mux16_scan_capture_settle_timer.sv
// Down-counter that measures the settle interval for each mux channel.
// done is high whenever the count has reached zero.
module scan_settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mux16_scan_capture.sv
// Walks a 16:1 mux select through all channels, samples y_in after a settle
// delay on each, and presents the completed 16-bit word with a valid/ready handshake.
module mux16_scan_capture
  import mux16_scan_capture_pkg::*;
#(
  parameter int unsigned SETTLE     = 2,
  parameter bit          INVERT_Y   = 1'b0,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  y_in,
  input  logic                  ready,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic                  busy,
  output logic [SCAN_WIDTH-1:0] data,
  output logic                  valid
);

  // With no settle time each channel goes straight to its sample cycle.
  localparam scan_state_e FIRST_STATE = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic [3:0]  SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  scan_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [SCAN_WIDTH-1:0] shadow_q, shadow_d;
  logic [SCAN_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  tmr_load, tmr_count, tmr_done;

  scan_settle_timer #(.WIDTH(4)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Abort overrides everything else, including the final capture into data.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    shadow_d  = shadow_q;
    data_d    = data_q;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = FIRST_STATE;
            sel_d    = '0;
            tmr_load = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr_done) begin
            state_d = ST_SAMPLE;
          end else begin
            tmr_count = 1'b1;
          end
        end
        ST_SAMPLE: begin
          shadow_d[sel_q] = y_in ^ INVERT_Y;
          if (sel_q == LAST_SEL) begin
            data_d  = shadow_d;
            sel_d   = '0;
            state_d = ST_DONE;
          end else begin
            sel_d    = sel_q + 1'b1;
            state_d  = FIRST_STATE;
            tmr_load = 1'b1;
          end
        end
        ST_DONE: begin
          if (ready) begin
            sel_d = '0;
            if (CONTINUOUS) begin
              state_d  = FIRST_STATE;
              tmr_load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end
      endcase
    end

    valid_d = (state_d == ST_DONE);
    busy_d  = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
  end

  assign sel   = sel_q;
  assign busy  = busy_q;
  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux16_scan_capture.sv
// Directed bench for mux16_scan_capture: three instances cover the default,
// inverted-capture and continuous configurations, each driving its own mux model.
module tb_mux16_scan_capture;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic        start_a, start_b, start_c;
  logic        ready_a, ready_b, ready_c;
  logic [15:0] d_a, d_b, d_c;
  logic        y_a, y_b, y_c;
  logic [3:0]  sel_a, sel_b, sel_c;
  logic        busy_a, busy_b, busy_c;
  logic [15:0] data_a, data_b, data_c;
  logic        valid_a, valid_b, valid_c;

  int total = 0;
  int bad   = 0;

  assign y_a = d_a[sel_a];
  assign y_b = d_b[sel_b];
  assign y_c = d_c[sel_c];

  mux16_scan_capture #(.SETTLE(2), .INVERT_Y(1'b0), .CONTINUOUS(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .y_in(y_a),
    .ready(ready_a), .sel(sel_a), .busy(busy_a), .data(data_a), .valid(valid_a)
  );

  mux16_scan_capture #(.SETTLE(2), .INVERT_Y(1'b1), .CONTINUOUS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .y_in(y_b),
    .ready(ready_b), .sel(sel_b), .busy(busy_b), .data(data_b), .valid(valid_b)
  );

  mux16_scan_capture #(.SETTLE(2), .INVERT_Y(1'b0), .CONTINUOUS(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort), .y_in(y_c),
    .ready(ready_c), .sel(sel_c), .busy(busy_c), .data(data_c), .valid(valid_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({sel_a, busy_a, valid_a, data_a} !== 22'h0) begin
      bad++;
      $display("[TB] FAIL reset_a: got sel=%0d busy=%b valid=%b data=%h, want all zero",
               sel_a, busy_a, valid_a, data_a);
    end
    total++;
    if ({sel_b, busy_b, valid_b, data_b, sel_c, busy_c, valid_c, data_c} !== 44'h0) begin
      bad++;
      $display("[TB] FAIL reset_bc: got b=%0d/%b/%b/%h c=%0d/%b/%b/%h, want all zero",
               sel_b, busy_b, valid_b, data_b, sel_c, busy_c, valid_c, data_c);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_scan();
    d_a = 16'hA5C3;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 48; k++) begin
      total++;
      if (sel_a !== 4'(k / 3) || busy_a !== 1'b1 || valid_a !== 1'b0) begin
        bad++;
        $display("[TB] FAIL scan_step k=%0d: got sel=%0d busy=%b valid=%b, want sel=%0d busy=1 valid=0",
                 k, sel_a, busy_a, valid_a, k / 3);
      end
      tick();
    end
    total++;
    if (valid_a !== 1'b1 || data_a !== 16'hA5C3 || busy_a !== 1'b0 || sel_a !== 4'd0) begin
      bad++;
      $display("[TB] FAIL scan_done: got valid=%b data=%h busy=%b sel=%0d, want 1 a5c3 0 0",
               valid_a, data_a, busy_a, sel_a);
    end
  endtask

  task automatic test_hold_ready();
    ready_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start_a = (i == 3);
      tick();
      total++;
      if (valid_a !== 1'b1 || data_a !== 16'hA5C3 || busy_a !== 1'b0) begin
        bad++;
        $display("[TB] FAIL hold_done i=%0d: got valid=%b data=%h busy=%b, want 1 a5c3 0",
                 i, valid_a, data_a, busy_a);
      end
    end
    ready_a = 1'b1;
    start_a = 1'b1;
    tick();
    ready_a = 1'b0;
    start_a = 1'b0;
    total++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || sel_a !== 4'd0) begin
      bad++;
      $display("[TB] FAIL handshake: got valid=%b busy=%b sel=%0d, want 0 0 0", valid_a, busy_a, sel_a);
    end
    tick();
    total++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0 || data_a !== 16'hA5C3) begin
      bad++;
      $display("[TB] FAIL idle_after_hs: got busy=%b valid=%b data=%h, want 0 0 a5c3",
               busy_a, valid_a, data_a);
    end
  endtask

  task automatic test_abort();
    logic saw_valid;
    saw_valid = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (22) tick();
    total++;
    if (sel_a !== 4'd7) begin
      bad++;
      $display("[TB] FAIL abort_pre: got sel=%0d, want 7", sel_a);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (sel_a !== 4'd0 || busy_a !== 1'b0 || valid_a !== 1'b0 || data_a !== 16'hA5C3) begin
      bad++;
      $display("[TB] FAIL abort_idle: got sel=%0d busy=%b valid=%b data=%h, want 0 0 0 a5c3",
               sel_a, busy_a, valid_a, data_a);
    end
    for (int i = 0; i < 60; i++) begin
      tick();
      if (valid_a !== 1'b0) saw_valid = 1'b1;
    end
    total++;
    if (saw_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_novalid: got valid seen=%b, want 0", saw_valid);
    end
  endtask

  task automatic test_abort_last_sample();
    d_a = 16'hFFFF;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (47) tick();
    abort = 1'b1;
    ready_a = 1'b1;
    tick();
    abort = 1'b0;
    ready_a = 1'b0;
    total++;
    if (valid_a !== 1'b0 || data_a !== 16'hA5C3 || busy_a !== 1'b0 || sel_a !== 4'd0) begin
      bad++;
      $display("[TB] FAIL abort_capture: got valid=%b data=%h busy=%b sel=%0d, want 0 a5c3 0 0",
               valid_a, data_a, busy_a, sel_a);
    end
    d_a = 16'hA5C3;
  endtask

  task automatic test_reset_midscan();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (27) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (sel_a !== 4'd0 || busy_a !== 1'b0 || valid_a !== 1'b0 || data_a !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL reset_mid: got sel=%0d busy=%b valid=%b data=%h, want 0 0 0 0000",
               sel_a, busy_a, valid_a, data_a);
    end
    #1;
    rst_n = 1'b1;
    tick();
    total++;
    if (busy_a !== 1'b0 || sel_a !== 4'd0) begin
      bad++;
      $display("[TB] FAIL reset_idle: got busy=%b sel=%0d, want 0 0", busy_a, sel_a);
    end
    d_a = 16'h3C96;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (48) tick();
    total++;
    if (valid_a !== 1'b1 || data_a !== 16'h3C96) begin
      bad++;
      $display("[TB] FAIL rescan: got valid=%b data=%h, want 1 3c96", valid_a, data_a);
    end
  endtask

  task automatic test_invert();
    d_b = 16'hA5C3;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (47) tick();
    total++;
    if (valid_b !== 1'b0 || busy_b !== 1'b1) begin
      bad++;
      $display("[TB] FAIL invert_early: got valid=%b busy=%b, want 0 1", valid_b, busy_b);
    end
    tick();
    total++;
    if (valid_b !== 1'b1 || data_b !== 16'h5A3C || busy_b !== 1'b0) begin
      bad++;
      $display("[TB] FAIL invert_data: got valid=%b data=%h busy=%b, want 1 5a3c 0",
               valid_b, data_b, busy_b);
    end
  endtask

  task automatic test_continuous();
    logic        exp_valid;
    logic [15:0] exp_word;
    d_c = 16'h1234;
    exp_word = 16'h1234;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int k = 0; k <= 146; k++) begin
      exp_valid = (k == 48) || (k == 97) || (k == 146);
      total++;
      if (valid_c !== exp_valid || (exp_valid && data_c !== exp_word)) begin
        bad++;
        $display("[TB] FAIL continuous k=%0d: got valid=%b data=%h, want valid=%b data=%h",
                 k, valid_c, data_c, exp_valid, exp_word);
      end
      if (k == 48) begin
        d_c = 16'hBEEF;
        exp_word = 16'hBEEF;
      end else if (k == 97) begin
        d_c = 16'h0F0F;
        exp_word = 16'h0F0F;
      end
      tick();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    abort   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    ready_c = 1'b1;
    d_a     = 16'hA5C3;
    d_b     = 16'hA5C3;
    d_c     = 16'h1234;

    test_reset();
    test_scan();
    test_hold_ready();
    test_abort();
    test_abort_last_sample();
    test_reset_midscan();
    test_invert();
    test_continuous();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
